layer2_fmap_tx: RTL and testbench

LAYER2_FMAP_TX -- requirements
Module: layer2_fmap_tx

---
 rtl/layer2_fmap_tx.sv | 151 +++++++++++++++
 tb/tb_layer2_fmap_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/layer2_fmap_tx.sv
// Stores one pooled 16-channel feature map and replays it as a vsync/href raster stream.
// Optional build macro FMAP_TX_AUTOSTART_EN starts replay automatically when a frame completes.
module layer2_fmap_tx #(
   parameter int WIDTH  = 14,
   parameter int HEIGHT = 14,
   parameter int H_GAP  = 4,
   parameter int V_GAP  = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vsync,
   input  logic         in_href,
   input  logic [255:0] in_data,
   input  logic         start,
   output logic         out_vsync,
   output logic         out_href,
   output logic [255:0] out_data,
   output logic [6:0]   out_h_cnt,
   output logic [6:0]   out_v_cnt,
   output logic         frame_ready,
   output logic         busy,
   output logic         tx_done,
   output logic         ovf_err
);

   localparam int NPIX = WIDTH * HEIGHT;
   localparam int AW   = $clog2(NPIX + 1);

   typedef enum logic [2:0] {IDLE, VS, LINE, HGAP, DONE} state_t;

   state_t         r_state;
   logic [255:0]   r_mem [0:(1<<AW)-1];
   logic [AW-1:0]  r_wr_addr;
   logic [AW-1:0]  r_rd_addr;
   logic [7:0]     r_gap_cnt;
   logic           r_vsync_d;

   logic           w_vs_rise;
   logic [AW-1:0]  w_wr_base;
   logic           w_wr_en;
   logic           w_drop;
   logic           w_start;

   // A new capture frame rewinds the write pointer in the same cycle it is seen.
   assign w_vs_rise = in_vsync & ~r_vsync_d;
   assign w_wr_base = w_vs_rise ? '0 : r_wr_addr;
   assign w_wr_en   = in_href & ~busy & (w_wr_base != AW'(NPIX));
   assign w_drop    = in_href & (busy | (w_wr_base == AW'(NPIX)));

`ifdef FMAP_TX_AUTOSTART_EN
   logic r_frame_ready_d;
   always_ff @(posedge clk) begin
      if (rst) r_frame_ready_d <= 1'b0;
      else     r_frame_ready_d <= frame_ready;
   end
   assign w_start = start | (frame_ready & ~r_frame_ready_d);
`else
   assign w_start = start;
`endif

   // NOTE: the pixel buffer has no reset; only the pointers and flags that qualify it do.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_base] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wr_addr   <= '0;
         r_rd_addr   <= '0;
         r_gap_cnt   <= '0;
         r_vsync_d   <= 1'b0;
         out_vsync   <= 1'b0;
         out_href    <= 1'b0;
         out_data    <= '0;
         out_h_cnt   <= '0;
         out_v_cnt   <= '0;
         frame_ready <= 1'b0;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
         ovf_err     <= 1'b0;
      end else begin
         r_vsync_d <= in_vsync;
         tx_done   <= 1'b0;
         r_wr_addr <= w_wr_en ? w_wr_base + AW'(1) : w_wr_base;
         if (w_drop) ovf_err <= 1'b1;
         if (w_wr_en && w_wr_base == AW'(NPIX - 1)) frame_ready <= 1'b1;
         else if (w_vs_rise)                         frame_ready <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_start && frame_ready) begin
                  r_state   <= VS;
                  out_vsync <= 1'b1;
                  busy      <= 1'b1;
                  r_gap_cnt <= '0;
                  r_rd_addr <= '0;
                  out_h_cnt <= '0;
                  out_v_cnt <= '0;
               end
            end
            VS: begin
               if (r_gap_cnt == 8'(V_GAP - 1)) begin
                  r_state   <= LINE;
                  out_href  <= 1'b1;
                  out_data  <= r_mem[r_rd_addr];
                  r_rd_addr <= r_rd_addr + AW'(1);
               end else begin
                  r_gap_cnt <= r_gap_cnt + 8'd1;
               end
            end
            LINE: begin
               // The read address always runs one pixel ahead of out_data.
               if (out_h_cnt == 7'(WIDTH - 1)) begin
                  out_href <= 1'b0;
                  out_data <= '0;
                  if (out_v_cnt == 7'(HEIGHT - 1)) begin
                     r_state     <= DONE;
                     out_vsync   <= 1'b0;
                     busy        <= 1'b0;
                     tx_done     <= 1'b1;
                     frame_ready <= 1'b0;
                  end else begin
                     r_state   <= HGAP;
                     r_gap_cnt <= '0;
                  end
               end else begin
                  out_h_cnt <= out_h_cnt + 7'd1;
                  out_data  <= r_mem[r_rd_addr];
                  r_rd_addr <= r_rd_addr + AW'(1);
               end
            end
            HGAP: begin
               if (r_gap_cnt == 8'(H_GAP - 1)) begin
                  r_state   <= LINE;
                  out_href  <= 1'b1;
                  out_data  <= r_mem[r_rd_addr];
                  r_rd_addr <= r_rd_addr + AW'(1);
                  out_h_cnt <= '0;
                  out_v_cnt <= out_v_cnt + 7'd1;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 8'd1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_layer2_fmap_tx.sv
// Directed bench for layer2_fmap_tx at WIDTH=4, HEIGHT=2, H_GAP=2, V_GAP=3.
// Build with FMAP_TX_AUTOSTART_EN defined to exercise the autostart variant instead.
module tb_layer2_fmap_tx;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int HG   = 2;
   localparam int VG   = 3;
   localparam int NPIX = W * H;
   localparam int LAST_VS = VG + NPIX + (H - 1) * HG;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_vsync = 1'b0;
   logic         in_href = 1'b0;
   logic [255:0] in_data = '0;
   logic         start = 1'b0;
   logic         out_vsync, out_href, frame_ready, busy, tx_done, ovf_err;
   logic [255:0] out_data;
   logic [6:0]   out_h_cnt, out_v_cnt;

   int n_vec = 0;
   int n_err = 0;

   layer2_fmap_tx #(.WIDTH(W), .HEIGHT(H), .H_GAP(HG), .V_GAP(VG)) dut (
      .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_href(in_href), .in_data(in_data),
      .start(start), .out_vsync(out_vsync), .out_href(out_href), .out_data(out_data),
      .out_h_cnt(out_h_cnt), .out_v_cnt(out_v_cnt), .frame_ready(frame_ready),
      .busy(busy), .tx_done(tx_done), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] pat(input int v);
      return {16{v[15:0]}};
   endfunction

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " vsync"}, out_vsync, 0);
      check({tag, " href"},  out_href, 0);
      check({tag, " data"},  out_data, 0);
      check({tag, " hcnt"},  out_h_cnt, 0);
      check({tag, " vcnt"},  out_v_cnt, 0);
      check({tag, " fready"}, frame_ready, 0);
      check({tag, " busy"},  busy, 0);
      check({tag, " done"},  tx_done, 0);
      check({tag, " ovf"},   ovf_err, 0);
   endtask

   // Leaves the caller at #1 after the edge that wrote the last pixel.
   task automatic capture(input int n);
      @(posedge clk); #1 in_vsync = 1'b1;
      @(posedge clk); #1 in_vsync = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_href = 1'b1;
         in_data = pat(i + 1);
         @(posedge clk); #1;
      end
      in_href = 1'b0;
      in_data = '0;
   endtask

   task automatic start_ignored(input string tag);
      bit seen = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (out_vsync || busy) seen = 1;
      end
      check(tag, seen, 0);
   endtask

   // Start at cycle t and check every output for cycles t+1 .. t+LAST_VS+3.
   task automatic replay(input bit inject);
      bit e_href;
      int e_row, e_col, s;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= LAST_VS + 3; k++) begin
         @(negedge clk);
         e_href = 0; e_row = 0; e_col = 0;
         for (int r = 0; r < H; r++) begin
            s = VG + 1 + r * (W + HG);
            if (k >= s && k < s + W) begin
               e_href = 1; e_row = r; e_col = k - s;
            end
         end
         check($sformatf("vsync t+%0d", k), out_vsync, (k <= LAST_VS));
         check($sformatf("busy t+%0d", k),  busy, (k <= LAST_VS));
         check($sformatf("href t+%0d", k),  out_href, e_href);
         check($sformatf("done t+%0d", k),  tx_done, (k == LAST_VS + 1));
         check($sformatf("data t+%0d", k),  out_data, e_href ? pat(e_row * W + e_col + 1) : '0);
         if (e_href || k == 1) begin
            check($sformatf("hcnt t+%0d", k), out_h_cnt, e_col);
            check($sformatf("vcnt t+%0d", k), out_v_cnt, e_row);
         end
         if (inject) begin
            in_vsync = (k == 2);
            in_href  = (k >= 3 && k <= 5);
            in_data  = in_href ? pat(16'hAAAA) : '0;
         end
      end
      in_vsync = 1'b0;
      in_href  = 1'b0;
      in_data  = '0;
      check("fready after replay", frame_ready, 0);
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      check_all_zero("reset");

`ifdef FMAP_TX_AUTOSTART_EN
      capture(NPIX);
      @(negedge clk);
      check("auto fready rise", frame_ready, 1);
      check("auto vsync same cycle", out_vsync, 0);
      @(negedge clk);
      check("auto vsync next cycle", out_vsync, 1);
      check("auto busy next cycle", busy, 1);
`else
      start_ignored("start without frame");

      capture(NPIX);
      @(negedge clk);
      check("fready after 8", frame_ready, 1);
      check("ovf after 8", ovf_err, 0);
      repeat (3) @(negedge clk);
      check("no autostart", out_vsync, 0);
      replay(1'b0);

      capture(NPIX + 1);
      @(negedge clk);
      check("fready after 9", frame_ready, 1);
      check("ovf after 9", ovf_err, 1);
      replay(1'b0);

      do_reset();
      @(negedge clk);
      check("ovf cleared by rst", ovf_err, 0);
      capture(NPIX);
      replay(1'b1);
      check("ovf after replay inject", ovf_err, 1);

      do_reset();
      capture(NPIX);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= VG + 1 + W + HG + 1; k++) @(negedge clk);
      check("mid hcnt", out_h_cnt, 1);
      check("mid vcnt", out_v_cnt, 1);
      check("mid href", out_href, 1);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid rst");
      @(posedge clk); #1 rst = 1'b0;
      start_ignored("start after rst");

      capture(NPIX);
      replay(1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
